// File: rtl/sram_pkg.sv
// Shared constants, FSM state type and address helper for the SRAM row controller.
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRE    = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } sram_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic addr_ok(input int unsigned addr, input int unsigned rows);
        return addr < rows;
    endfunction

endpackage

// File: rtl/sram_row_decoder.sv
// Address-to-one-hot wordline decoder; all-zero when disabled or the address is out of range.
module sram_row_decoder
    import sram_pkg::*;
#(
    parameter int ROWS = 6,
    parameter int AW   = 3
) (
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [ROWS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < ROWS; i++) begin
            onehot[i] = en && addr_ok(32'(addr), ROWS) && (32'(addr) == i);
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM row controller: precharge, then one timed wordline pulse, then a one-cycle response.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int AW      = 3,
    parameter int PRE_CYC = 2,
    parameter int WR_CYC  = 4,
    parameter int RD_CYC  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic            req_wdata,
    output logic            rsp_valid,
    output logic            rsp_rdata,
    output logic            rsp_err,
    output logic            precharge,
    output logic [ROWS-1:0] row_wr,
    output logic [ROWS-1:0] row_rd,
    output real             data_in,
    input  real             preout
);

    localparam int CNT_MAX = int'(max3(PRE_CYC, WR_CYC, RD_CYC));
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    sram_state_e   state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic          err_q;
    logic          accept;
    logic          legal;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and outside reset, and the response has no ready.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign legal     = addr_ok(32'(req_addr), ROWS);

    assign precharge = (state == PRE);
    assign rsp_valid = (state == DONE);
    assign rsp_err   = (state == DONE) && err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            rsp_rdata <= 1'b0;
            data_in   <= VSS;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q   <= req_we;
                        addr_q <= req_addr;
                        err_q  <= !legal;
                        if (req_we) begin
                            data_in <= req_wdata ? VDD : VSS;
                        end
                        if (legal) begin
                            state <= PRE;
                            cnt   <= CW'(PRE_CYC - 1);
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        state <= ACCESS;
                        cnt   <= we_q ? CW'(WR_CYC - 1) : CW'(RD_CYC - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        // Sense on the final wordline cycle so the bitline has fully developed.
                        if (!we_q) begin
                            rsp_rdata <= (preout >= VTH);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sram_row_decoder #(.ROWS(ROWS), .AW(AW)) u_dec_wr (
        .en     ((state == ACCESS) && we_q),
        .addr   (addr_q),
        .onehot (row_wr)
    );

    sram_row_decoder #(.ROWS(ROWS), .AW(AW)) u_dec_rd (
        .en     ((state == ACCESS) && !we_q),
        .addr   (addr_q),
        .onehot (row_rd)
    );

endmodule
